// File: rtl/case3_resp_capture.sv
// Response capture for the Case3 logic stage: folds len samples of y_in into a
// CRC-16 (0x1021) MISR and counts ones. Define RESP_SYNC_EN to resynchronize y_in.
module case3_resp_capture #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [SIG_W-1:0] SIG_SEED = '1;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

  // State bits double as the busy/done flops, so neither output has decode logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [SIG_W-1:0] r_signature;
  logic [CNT_W-1:0] r_ones_cnt;

  logic             w_s;
  logic             w_accept;
  logic             w_fb;
  logic [SIG_W-1:0] w_sig_nxt;

`ifdef RESP_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Free-running so the two-cycle latency is the same whatever the FSM is doing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= y_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = y_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment at the top keeps this block latch-free even
  // when a branch leaves the next state unassigned.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_remaining == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = r_state[0];
    done = r_state[1];
  end

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_fb      = r_signature[SIG_W-1] ^ w_s;
  assign w_sig_nxt = {r_signature[SIG_W-2:0], 1'b0} ^ (w_fb ? SIG_POLY : '0);

  // NOTE: the asynchronous reset covers every datapath register, so an aborted
  // capture leaves no partial signature or count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_signature <= SIG_SEED;
      r_ones_cnt  <= '0;
    end else if (w_accept) begin
      r_remaining <= len;
      r_signature <= SIG_SEED;
      r_ones_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_remaining <= r_remaining - CNT_W'(1);
      r_signature <= w_sig_nxt;
      if (w_s && (r_ones_cnt != '1)) begin
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
    end
  end

  assign signature = r_signature;
  assign ones_cnt  = r_ones_cnt;

endmodule
